pong_game_ctrl: RTL
===================

# pong_game_ctrl

Game-sequencing controller for the two-player Pong datapath. Consumes the graphics block's `missLeft`/`missRight` flags and the player buttons, keeps both scores, and drives `gra_still` so the ball is held at centre during the new-game, serve and game-over phases. Sits between the button inputs, the graphics block and the score/text overlay logic.

## Interface
Parameters:
- `WIN_SCORE`, 7: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, 120: frame ticks the ball is held before a serve (2 s at 60 Hz); legal range 1..255.

Ports:
- `clk`  input  1  system/pixel clock.
- `reset`  input  1  asynchronous, active-high.
- `frame_tick`  input  1  one-cycle pulse per frame, at the start of vertical retrace.
- `btn`  input  2  left player buttons {down, up}, debounced.
- `btn1`  input  2  right player buttons {down, up}, debounced.
- `missLeft`  input  1  ball has passed the left edge; the right player scores.
- `missRight`  input  1  ball has passed the right edge; the left player scores.
- `gra_still`  output  1  hold the ball at centre and reset its velocity.
- `score_l`  output  4  left player score.
- `score_r`  output  4  right player score.
- `game_state`  output  2  00 NEWGAME, 01 PLAY, 10 SERVE, 11 OVER.
- `winner`  output  2  01 left won, 10 right won, 00 no winner.

## Operation
- `start = |{btn, btn1}`. `start_d` is `start` registered, and resets to 1 so a button held through reset does not register a press. `start_rise = start & ~start_d`.
- FSM, Moore outputs. `gra_still = (state != PLAY)`.
  - NEWGAME: scores = 0, winner = 00. On `start_rise`, go to PLAY.
  - PLAY: on `missRight` (priority when both misses are high in the same cycle), `score_l` += 1. Otherwise on `missLeft`, `score_r` += 1. If the new score equals `WIN_SCORE`, go to OVER and set `winner`. Otherwise go to SERVE.
  - SERVE: the serve timer is active. Exit to PLAY per the Configuration section. Misses are ignored.
  - OVER: scores and `winner` are frozen and misses are ignored. On `start_rise`, go to NEWGAME, which clears the scores and `winner` on entry.
- Serve timer: 8-bit down-counter.
  - Loaded with `SERVE_FRAMES-1` on every transition into SERVE.
  - Decrements on `frame_tick` while in SERVE.
  - SERVE ends on the `frame_tick` at which the count is 0, so exactly `SERVE_FRAMES` ticks elapse.
- Score arithmetic is 4-bit unsigned. A score never exceeds `WIN_SCORE` because reaching it forces OVER, so no wrap is possible.
- Reset, including mid-operation: state = NEWGAME, `score_l` = `score_r` = 0, `winner` = 00, timer = 0, `start_d` = 1, `gra_still` = 1, `game_state` = 00. Effect is immediate (asynchronous).

## Timing
- All outputs are registered or decoded purely from registers. There are no combinational input-to-output paths.
- Miss sampled high at edge N: at edge N the state becomes SERVE/OVER and the score updates. `gra_still` is high from N onward, and the graphics block recentres the ball at edge N+1.
- A miss still high during cycle N+1 is ignored because the state is no longer PLAY. This gives exactly one point per miss event.
- Button press registered at edge N: `start_rise` is high during cycle N, and the state changes at edge N+1.
- The SERVE to PLAY transition happens on the clock edge that samples the final `frame_tick`. `gra_still` falls that same edge.
- `frame_tick` coincident with the transition into SERVE does not decrement, because the load takes priority.

## Configuration
- `PONG_CTRL_AUTOSERVE_EN` defined: SERVE exits on serve-timer expiry; buttons are ignored in SERVE.
- Not defined: SERVE exits only on `start_rise`. The timer and `SERVE_FRAMES` are unused and may be optimised away. `frame_tick` is ignored.

## Test plan
- Reset, then hold NEWGAME for 100 cycles with no buttons -> `game_state`=00, `gra_still`=1, scores 0/0. Pulse `btn[0]` -> PLAY on the next edge, `gra_still`=0.
- In PLAY, hold `missRight` high for 5 cycles -> `score_l`=1 (not 5), state SERVE. With AUTOSERVE_EN and `SERVE_FRAMES`=3: 3 `frame_tick`s -> PLAY; after 2 ticks -> still SERVE.
- Assert `missLeft` and `missRight` in the same cycle in PLAY -> `score_l`+1 only, `score_r` unchanged.
- `WIN_SCORE`=2, two `missLeft` events -> `score_r`=2, state OVER, `winner`=10, `gra_still`=1. A further miss -> no change. Press `btn1[1]` -> NEWGAME, scores 0/0, `winner`=00.
- Hold `btn[1]` through reset release -> stays NEWGAME until the button is released and pressed again.
- Assert reset mid-SERVE with score 3/2 -> all outputs take reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, serve/over phases and ball hold control.
// Optional PONG_CTRL_AUTOSERVE_EN: serve ends on frame-tick timer instead of a button press.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] btn,
    input  logic [1:0] btn1,
    input  logic       missLeft,
    input  logic       missRight,
    output logic       gra_still,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] game_state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        SERVE   = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state;
    state_t     state_next;
    logic [3:0] score_l_next;
    logic [3:0] score_r_next;
    logic [1:0] winner_next;
    logic       start;
    logic       start_d;
    logic       start_rise;
    logic       serve_done;

    assign start      = |{btn, btn1};
    assign start_rise = start & ~start_d;

`ifdef PONG_CTRL_AUTOSERVE_EN
    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);

    logic [7:0] timer;

    // Load wins over a coincident tick on SERVE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state != SERVE && state_next == SERVE) begin
            timer <= SERVE_LOAD;
        end else if (state == SERVE && frame_tick && timer != 8'd0) begin
            timer <= timer - 8'd1;
        end
    end

    assign serve_done = frame_tick && (timer == 8'd0);
`else
    logic [8:0] unused_serve;

    assign unused_serve = {frame_tick, 8'(SERVE_FRAMES)};
    assign serve_done   = start_rise;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NEWGAME;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_l <= '0;
            score_r <= '0;
            winner  <= '0;
            start_d <= 1'b1;
        end else begin
            score_l <= score_l_next;
            score_r <= score_r_next;
            winner  <= winner_next;
            start_d <= start;
        end
    end

    always_comb begin
        state_next   = state;
        score_l_next = score_l;
        score_r_next = score_r;
        winner_next  = winner;
        unique case (state)
            NEWGAME: begin
                score_l_next = '0;
                score_r_next = '0;
                winner_next  = '0;
                if (start_rise) state_next = PLAY;
            end
            PLAY: begin
                if (missRight) begin
                    score_l_next = score_l + 4'd1;
                    if (score_l_next == WIN) begin
                        state_next  = OVER;
                        winner_next = 2'b01;
                    end else begin
                        state_next = SERVE;
                    end
                end else if (missLeft) begin
                    score_r_next = score_r + 4'd1;
                    if (score_r_next == WIN) begin
                        state_next  = OVER;
                        winner_next = 2'b10;
                    end else begin
                        state_next = SERVE;
                    end
                end
            end
            SERVE: begin
                if (serve_done) state_next = PLAY;
            end
            OVER: begin
                if (start_rise) begin
                    state_next   = NEWGAME;
                    score_l_next = '0;
                    score_r_next = '0;
                    winner_next  = '0;
                end
            end
            default: state_next = NEWGAME;
        endcase
    end

    always_comb begin
        gra_still  = (state != PLAY);
        game_state = state;
    end

endmodule
